// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl
//   Iterative AES inverse cipher. One ciphertext block is accepted, then one
//   decryption round is applied per clock on a shared round datapath
//   (InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns). Round keys
//   come from an external key-schedule store addressed by rk_idx. The
//   plaintext is returned through a valid/ready handshake.
// Ports
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    ciphertext handshake, in_data = ciphertext
//   rk_idx               round-key index requested this cycle
//   rk_data/rk_valid     round key for rk_idx (same cycle), low valid = stall
//   out_valid/out_ready  plaintext handshake, out_data = plaintext
//   busy                 high whenever the controller is not idle
// Byte order: byte 0 in [127:120], column-major (column c = [127-32c -: 32]).
`timescale 1ns/1ps

// One state column: InvSubBytes, AddRoundKey, optional InvMixColumns.
// i_col arrives already InvShiftRows-permuted.
module aes_inv_col (
  input  logic [31:0] i_col,
  input  logic [31:0] i_key,
  input  logic        i_mix,
  output logic [31:0] o_col
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, bb;
    p  = 8'h00;
    x  = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ x;
      x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  // Inverse S-box: inverse affine transform followed by GF(2^8) inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[1]^b[4]^b[6], b[0]^b[3]^b[5], b[7]^b[2]^b[4], b[6]^b[1]^b[3],
         b[5]^b[0]^b[2], b[4]^b[7]^b[1], b[3]^b[6]^b[0], b[2]^b[5]^b[7]};
    return ginv(t ^ 8'h05);
  endfunction

  logic [7:0]  w_a0, w_a1, w_a2, w_a3;
  logic [31:0] w_mixed;

  assign w_a0 = inv_sbox(i_col[31:24]) ^ i_key[31:24];
  assign w_a1 = inv_sbox(i_col[23:16]) ^ i_key[23:16];
  assign w_a2 = inv_sbox(i_col[15:8])  ^ i_key[15:8];
  assign w_a3 = inv_sbox(i_col[7:0])   ^ i_key[7:0];

  assign w_mixed = {
    gmul(w_a0, 8'h0e) ^ gmul(w_a1, 8'h0b) ^ gmul(w_a2, 8'h0d) ^ gmul(w_a3, 8'h09),
    gmul(w_a0, 8'h09) ^ gmul(w_a1, 8'h0e) ^ gmul(w_a2, 8'h0b) ^ gmul(w_a3, 8'h0d),
    gmul(w_a0, 8'h0d) ^ gmul(w_a1, 8'h09) ^ gmul(w_a2, 8'h0e) ^ gmul(w_a3, 8'h0b),
    gmul(w_a0, 8'h0b) ^ gmul(w_a1, 8'h0d) ^ gmul(w_a2, 8'h09) ^ gmul(w_a3, 8'h0e)};

  assign o_col = i_mix ? w_mixed : {w_a0, w_a1, w_a2, w_a3};
endmodule

module aes_inv_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  input  logic         rk_valid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam logic [3:0] NR4 = 4'(NR);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_e;

  state_e       r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_rnd;
  logic         r_out_valid;
  logic         r_busy;

  logic [127:0] w_shift;
  logic [127:0] w_round;
  logic         w_mix;

  // Full rounds mix columns; the last round skips InvMixColumns.
  assign w_mix = (r_fsm == S_ROUND);

  // InvShiftRows: row r rotates right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_shift[127-8*(4*c+r) -: 8] = r_state[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
    aes_inv_col u_col (
      .i_col (w_shift[127-32*c -: 32]),
      .i_key (rk_data[127-32*c -: 32]),
      .i_mix (w_mix),
      .o_col (w_round[127-32*c -: 32])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_rnd       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid && rk_valid) begin
            r_state <= in_data ^ rk_data;
            r_rnd   <= NR4 - 4'd1;
            r_fsm   <= S_ROUND;
            r_busy  <= 1'b1;
          end
        end
        S_ROUND: begin
          // A missing round key freezes everything, including rk_idx.
          if (rk_valid) begin
            r_state <= w_round;
            if (r_rnd == 4'd1) r_fsm <= S_FINAL;
            else               r_rnd <= r_rnd - 4'd1;
          end
        end
        S_FINAL: begin
          if (rk_valid) begin
            r_state     <= w_round;
            r_fsm       <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_fsm       <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  // Key index depends only on FSM state and round counter.
  always_comb begin
    rk_idx = NR4;
    case (r_fsm)
      S_IDLE:  rk_idx = NR4;
      S_ROUND: rk_idx = r_rnd;
      S_FINAL: rk_idx = 4'd0;
      default: rk_idx = NR4;
    endcase
  end

  assign in_ready  = (r_fsm == S_IDLE) && rk_valid;
  assign out_valid = r_out_valid;
  assign out_data  = r_state;
  assign busy      = r_busy;
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Testbench for aes_inv_round_ctrl (NR=10). Expected plaintexts are pushed
// into a queue when a block is issued; a monitor pops and compares on every
// output handshake. Random blocks are produced by a forward AES-128 model
// (encrypt random plaintext, expect the plaintext back).
`timescale 1ns/1ps

module tb_aes_inv_round_ctrl;
  localparam int NR = 10;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, rk_valid = 1'b1, out_ready = 1'b1;
  logic         in_ready, out_valid, busy;
  logic [127:0] in_data = '0, rk_data, out_data;
  logic [3:0]   rk_idx;

  logic [127:0] rk_tab [16];
  logic [7:0]   sbox [256];
  logic [127:0] exp_q [$];
  int           n_checks = 0, n_err = 0;
  bit           stream_done = 1'b0;

  always #5 clk = ~clk;
  assign rk_data = rk_tab[rk_idx];

  aes_inv_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rk_idx(rk_idx), .rk_data(rk_data), .rk_valid(rk_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // ---------------- reference model: forward AES-128 ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-box from log/antilog tables (generator 3) plus the forward affine map.
  task automatic build_sbox();
    logic [7:0] alog [256];
    int         lg [256];
    logic [7:0] a, inv;
    a = 8'h01;
    for (int i = 0; i < 255; i++) begin
      alog[i] = a;
      lg[a]   = i;
      a       = a ^ xt(a);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : alog[(255 - lg[x]) % 255];
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127-8*(4*c+rw) -: 8] = sbox[s[127-8*(4*((c+rw)%4)+rw) -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r < NR; r++) s = mix(sub_shift(s)) ^ rk_tab[r];
    return sub_shift(s) ^ rk_tab[NR];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [127:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_output: got %0h want none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Returns at accepting edge + 1ns.
  task automatic send(input logic [127:0] ct, output bit ok);
    in_valid = 1'b1;
    in_data  = ct;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 500) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("drain_remaining", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;
    logic [127:0] pt, ct;

    build_sbox();
    set_key(C1_KEY);

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_rk_idx", rk_idx, 10);
    chk("rst_in_ready", in_ready, 1);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.1
    exp_q.push_back(C1_PT);
    send(C1_CT, ok);
    chk("c1_accept", ok, 1);
    chk("c1_busy", busy, 1);
    chk("c1_rk_idx_first", rk_idx, 9);
    wait_valid(n);
    chk("c1_latency", n, 10);
    wait_drain();

    // FIPS-197 App. B
    set_key(B_KEY);
    exp_q.push_back(B_PT);
    send(B_CT, ok);
    chk("b_accept", ok, 1);
    wait_valid(n);
    chk("b_latency", n, 10);
    wait_drain();

    // Key-schedule stall during round 5
    set_key(C1_KEY);
    exp_q.push_back(C1_PT);
    send(C1_CT, ok);
    n = 0;
    repeat (4) begin @(posedge clk); #1; n++; end
    chk("stall_rk_idx_pre", rk_idx, 5);
    rk_valid = 1'b0;
    chk("stall_in_ready", in_ready, 0);
    repeat (3) begin
      @(posedge clk); #1; n++;
      chk("stall_rk_idx_held", rk_idx, 5);
    end
    rk_valid = 1'b1;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("stall_latency", n, 13);
    wait_drain();

    // Output backpressure, next block offered while DONE
    out_ready = 1'b0;
    exp_q.push_back(C1_PT);
    send(C1_CT, ok);
    wait_valid(n);
    chk("bp_latency", n, 10);
    set_key(B_KEY);
    exp_q.push_back(B_PT);
    in_valid = 1'b1;
    in_data  = B_CT;
    repeat (4) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, C1_PT);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_out_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_busy", busy, 1);
    wait_valid(n);
    chk("bp_next_latency", n, 10);
    wait_drain();

    // Reset during round 6 discards the block
    set_key(C1_KEY);
    send(C1_CT, ok);
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_mid_rk_idx", rk_idx, 6);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(C1_PT);
    send(C1_CT, ok);
    chk("rst_after_accept", ok, 1);
    wait_valid(n);
    chk("rst_after_latency", n, 10);
    wait_drain();

    // Random stream with random backpressure
    set_key({$urandom, $urandom, $urandom, $urandom});
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          pt = {$urandom, $urandom, $urandom, $urandom};
          ct = enc(pt);
          exp_q.push_back(pt);
          send(ct, ok);
          chk("stream_accept", ok, 1);
        end
        wait_drain();
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("final_out_valid", out_valid, 0);
    chk("final_queue", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
